mem_port_arbiter: RTL and testbench

Two-master arbiter sharing the single-port program/data memory (9-bit address, 16-bit data, MREAD/MWRITE command encoding).
- Port 0 is the CPU fetch/load/store interface.
- Port 1 is a secondary master, e.g. a boot loader, debug or DMA engine.
- Registered grant FSM with round-robin fairness.
- Sequences the one-cycle read latency of the synchronous RAM and returns a one-cycle acknowledge per transaction.

---
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous RAM.
// Define LOCK_EN to add lock0/lock1 inputs that let a granted port keep priority.
module mem_port_arbiter #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
`ifdef LOCK_EN
  input  logic          lock0,
  input  logic          lock1,
`endif
  input  logic          req0,
  input  logic [1:0]    cmd0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic [1:0]    cmd1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic            grant_q, grant_d;
  logic [1:0]      mem_cmd_q, mem_cmd_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic            busy_q, busy_d;
  logic            valid0, valid1;
  logic            win;

  assign valid0 = req0 && ((cmd0 == CMD_READ) || (cmd0 == CMD_WRITE));
  assign valid1 = req1 && ((cmd1 == CMD_READ) || (cmd1 == CMD_WRITE));

`ifdef LOCK_EN
  logic lock_hold_q, lock_hold_d;
  logic granted_lock;

  assign granted_lock = grant_q ? lock1 : lock0;
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    mem_cmd_d   = mem_cmd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    win         = 1'b0;
`ifdef LOCK_EN
    lock_hold_d = lock_hold_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef LOCK_EN
        // A held lock only applies to this one IDLE cycle.
        lock_hold_d = 1'b0;
`endif
        if (valid0 || valid1) begin
          if (valid0 && valid1) begin
`ifdef LOCK_EN
            win = lock_hold_q ? grant_q : ~last_q;
`else
            win = ~last_q;
`endif
          end else begin
            win = valid1;
          end
          grant_d     = win;
          mem_cmd_d   = win ? cmd1   : cmd0;
          mem_addr_d  = win ? addr1  : addr0;
          mem_wdata_d = win ? wdata1 : wdata0;
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
        mem_cmd_d = CMD_NONE;
        if (mem_cmd_q == CMD_WRITE) begin
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          state_d = DONE;
        end else begin
          state_d = RWAIT;
        end
      end

      RWAIT: begin
        // RAM data for the MREAD issued last cycle is valid now.
        rdata_d = mem_rdata;
        ack0_d  = ~grant_q;
        ack1_d  = grant_q;
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
`ifdef LOCK_EN
        if (granted_lock) begin
          lock_hold_d = 1'b1;
        end else begin
          last_d = grant_q;
        end
`else
        last_d = grant_q;
`endif
      end

      default: begin
        state_d   = IDLE;
        mem_cmd_d = CMD_NONE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      mem_cmd_q   <= CMD_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef LOCK_EN
      lock_hold_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      mem_cmd_q   <= mem_cmd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      busy_q      <= busy_d;
`ifdef LOCK_EN
      lock_hold_q <= lock_hold_d;
`endif
    end
  end

  assign mem_cmd   = mem_cmd_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small synchronous RAM model.
// Define LOCK_EN for both files to exercise the lock feature.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic [1:0]  cmd0, cmd1;
  logic [8:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;
`ifdef LOCK_EN
  logic        lock0, lock1;
`endif

  int tests_run;
  int tests_failed;

  logic [15:0] ram [0:511];

  mem_port_arbiter #(.AW(9), .DW(16)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef LOCK_EN
    .lock0     (lock0),
    .lock1     (lock1),
`endif
    .req0      (req0),
    .cmd0      (cmd0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .ack0      (ack0),
    .req1      (req1),
    .cmd1      (cmd1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ack1      (ack1),
    .rdata     (rdata),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after MREAD.
  always @(posedge clk) begin
    if (mem_cmd == 2'b01) mem_rdata <= ram[mem_addr];
    else if (mem_cmd == 2'b10) ram[mem_addr] <= mem_wdata;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req0 = 1'b0; cmd0 = 2'b00; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; cmd1 = 2'b00; addr1 = '0; wdata1 = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    tests_run++; if (mem_cmd !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_mem_cmd got %b expected 00", mem_cmd); end
    tests_run++; if (mem_addr !== 9'h000) begin tests_failed++; $display("[TB] FAIL reset_mem_addr got %h expected 000", mem_addr); end
    tests_run++; if (mem_wdata !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_mem_wdata got %h expected 0000", mem_wdata); end
    tests_run++; if (rdata !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_rdata got %h expected 0000", rdata); end
    tests_run++; if ({ack0, ack1} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_acks got %b expected 00", {ack0, ack1}); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_port0;
    req0 = 1'b1; cmd0 = 2'b10; addr0 = 9'h005; wdata0 = 16'hABCD;
    tick();
    tests_run++; if (mem_cmd !== 2'b10) begin tests_failed++; $display("[TB] FAIL wr_mem_cmd got %b expected 10", mem_cmd); end
    tests_run++; if (mem_addr !== 9'h005) begin tests_failed++; $display("[TB] FAIL wr_mem_addr got %h expected 005", mem_addr); end
    tests_run++; if (mem_wdata !== 16'hABCD) begin tests_failed++; $display("[TB] FAIL wr_mem_wdata got %h expected abcd", mem_wdata); end
    tests_run++; if ({ack0, ack1, busy} !== 3'b001) begin tests_failed++; $display("[TB] FAIL wr_cycle1 ack0/ack1/busy got %b expected 001", {ack0, ack1, busy}); end
    tick();
    tests_run++; if ({ack0, ack1, busy} !== 3'b101) begin tests_failed++; $display("[TB] FAIL wr_ack ack0/ack1/busy got %b expected 101", {ack0, ack1, busy}); end
    tests_run++; if (mem_cmd !== 2'b00) begin tests_failed++; $display("[TB] FAIL wr_cmd_cleared got %b expected 00", mem_cmd); end
    idle_inputs();
    tick();
    tests_run++; if ({ack0, ack1, busy} !== 3'b000) begin tests_failed++; $display("[TB] FAIL wr_after ack0/ack1/busy got %b expected 000", {ack0, ack1, busy}); end
    tests_run++; if (rdata !== 16'h0000) begin tests_failed++; $display("[TB] FAIL wr_rdata_untouched got %h expected 0000", rdata); end
    tick();
  endtask

  task automatic test_read_port1;
    ram[9'h1F0] = 16'h1234;
    req1 = 1'b1; cmd1 = 2'b01; addr1 = 9'h1F0;
    tick();
    tests_run++; if ({mem_cmd, mem_addr} !== {2'b01, 9'h1F0}) begin tests_failed++; $display("[TB] FAIL rd_issue cmd/addr got %b/%h expected 01/1f0", mem_cmd, mem_addr); end
    tests_run++; if ({ack0, ack1, busy} !== 3'b001) begin tests_failed++; $display("[TB] FAIL rd_cycle1 ack0/ack1/busy got %b expected 001", {ack0, ack1, busy}); end
    tick();
    tests_run++; if ({ack0, ack1, busy, mem_cmd} !== 5'b00100) begin tests_failed++; $display("[TB] FAIL rd_cycle2 ack0/ack1/busy/cmd got %b expected 00100", {ack0, ack1, busy, mem_cmd}); end
    tick();
    tests_run++; if ({ack0, ack1, busy} !== 3'b011) begin tests_failed++; $display("[TB] FAIL rd_ack ack0/ack1/busy got %b expected 011", {ack0, ack1, busy}); end
    tests_run++; if (rdata !== 16'h1234) begin tests_failed++; $display("[TB] FAIL rd_rdata got %h expected 1234", rdata); end
    idle_inputs();
    tick();
    tests_run++; if ({ack0, ack1, busy} !== 3'b000) begin tests_failed++; $display("[TB] FAIL rd_after ack0/ack1/busy got %b expected 000", {ack0, ack1, busy}); end
    tests_run++; if (rdata !== 16'h1234) begin tests_failed++; $display("[TB] FAIL rd_rdata_hold got %h expected 1234", rdata); end
    tick();
  endtask

  task automatic test_back_to_back;
    int n_ack0;
    int n_ack1;
    int waited;
    bit expect1;
    logic [15:0] exp_data;
    logic [8:0]  exp_addr;
    ram[9'h010] = 16'h1111;
    ram[9'h020] = 16'h2222;
    idle_inputs();
    do_reset();
    n_ack0 = 0;
    n_ack1 = 0;
    req0 = 1'b1; cmd0 = 2'b01; addr0 = 9'h010;
    req1 = 1'b1; cmd1 = 2'b01; addr1 = 9'h020;
    for (int t = 0; t < 4; t++) begin
      expect1  = t[0];
      exp_addr = expect1 ? 9'h020 : 9'h010;
      exp_data = expect1 ? 16'h2222 : 16'h1111;
      waited = 0;
      tick();
      while (!(ack0 || ack1) && waited < 8) begin
        if (mem_cmd == 2'b01) begin
          tests_run++; if (mem_addr !== exp_addr) begin tests_failed++; $display("[TB] FAIL b2b_mem_addr txn %0d got %h expected %h", t, mem_addr, exp_addr); end
        end
        tick();
        waited++;
      end
      tests_run++;
      if (waited >= 8) begin
        tests_failed++; $display("[TB] FAIL b2b_timeout txn %0d no ack within 8 cycles", t);
      end else begin
        if (ack0) n_ack0++;
        if (ack1) n_ack1++;
        if ({ack0, ack1} !== {~expect1, expect1}) begin tests_failed++; $display("[TB] FAIL b2b_grant txn %0d ack0/ack1 got %b expected %b", t, {ack0, ack1}, {~expect1, expect1}); end
        tests_run++; if (rdata !== exp_data) begin tests_failed++; $display("[TB] FAIL b2b_rdata txn %0d got %h expected %h", t, rdata, exp_data); end
      end
    end
    tests_run++; if (n_ack0 !== 2 || n_ack1 !== 2) begin tests_failed++; $display("[TB] FAIL b2b_ack_counts got %0d/%0d expected 2/2", n_ack0, n_ack1); end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid;
    int waited;
    ram[9'h030] = 16'h3333;
    tests_run++; if (rdata !== 16'h2222) begin tests_failed++; $display("[TB] FAIL mid_rdata_before got %h expected 2222", rdata); end
    req1 = 1'b1; cmd1 = 2'b01; addr1 = 9'h030;
    tick();
    tick();
    reset = 1'b1;
    #1;
    tests_run++; if ({mem_cmd, busy, ack0, ack1} !== 5'b00000) begin tests_failed++; $display("[TB] FAIL mid_reset cmd/busy/ack0/ack1 got %b expected 00000", {mem_cmd, busy, ack0, ack1}); end
    tests_run++; if (rdata !== 16'h0000) begin tests_failed++; $display("[TB] FAIL mid_reset_rdata got %h expected 0000", rdata); end
    tick();
    tick();
    tests_run++; if ({ack0, ack1, busy} !== 3'b000) begin tests_failed++; $display("[TB] FAIL mid_reset_held ack0/ack1/busy got %b expected 000", {ack0, ack1, busy}); end
    reset = 1'b0;
    waited = 0;
    tick();
    waited++;
    while (!ack1 && waited < 8) begin
      tick();
      waited++;
    end
    tests_run++; if (waited !== 3) begin tests_failed++; $display("[TB] FAIL mid_recover_latency got %0d cycles expected 3", waited); end
    tests_run++; if ({ack0, ack1, rdata} !== {2'b01, 16'h3333}) begin tests_failed++; $display("[TB] FAIL mid_recover ack0/ack1/rdata got %b%b/%h expected 01/3333", ack0, ack1, rdata); end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_invalid_cmd;
    int bad;
    bad = 0;
    req0 = 1'b1; cmd0 = 2'b11; addr0 = 9'h0AA; wdata0 = 16'h5555;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 5) cmd0 = 2'b00;
      if ({mem_cmd, ack0, ack1, busy} !== 5'b00000) bad++;
    end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("[TB] FAIL invalid_cmd got %0d bad cycles expected 0", bad); end
    idle_inputs();
    tick();
  endtask

`ifdef LOCK_EN
  task automatic test_lock;
    int waited;
    idle_inputs();
    lock0 = 1'b1;
    lock1 = 1'b0;
    do_reset();
    req0 = 1'b1; cmd0 = 2'b10; addr0 = 9'h040; wdata0 = 16'h0404;
    req1 = 1'b1; cmd1 = 2'b10; addr1 = 9'h041; wdata1 = 16'h1414;
    for (int t = 0; t < 4; t++) begin
      waited = 0;
      tick();
      while (!(ack0 || ack1) && waited < 8) begin
        tick();
        waited++;
      end
      if (t == 3) lock0 = 1'b0;
      tests_run++; if ({ack0, ack1} !== 2'b10) begin tests_failed++; $display("[TB] FAIL lock_hold txn %0d ack0/ack1 got %b expected 10", t, {ack0, ack1}); end
    end
    waited = 0;
    tick();
    while (!(ack0 || ack1) && waited < 8) begin
      tick();
      waited++;
    end
    tests_run++; if ({ack0, ack1} !== 2'b01) begin tests_failed++; $display("[TB] FAIL lock_release ack0/ack1 got %b expected 01", {ack0, ack1}); end
    idle_inputs();
    tick();
    tick();
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    mem_rdata    = '0;
    reset        = 1'b0;
`ifdef LOCK_EN
    lock0 = 1'b0;
    lock1 = 1'b0;
`endif
    idle_inputs();
    test_reset();
    test_write_port0();
    test_read_port1();
    test_back_to_back();
    test_reset_mid();
    test_invalid_cmd();
`ifdef LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

endmodule
